// File: rtl/ppi_pkg.sv
// ppi_pkg: shared types, defaults and helpers for the polyphase serializer.
//   ppi_state_e     : serializer FSM state (IDLE / RUN)
//   ppi_clog2()     : ceil(log2(n)), used for the phase counter width
//   PPI_* constants : default parameter values for ppi_serializer
package ppi_pkg;

   localparam int unsigned PPI_CHANNELS    = 32;
   localparam int unsigned PPI_CHAN_WIDTH  = 32;
   localparam int unsigned PPI_ODATA_WIDTH = 16;
   localparam int unsigned PPI_MSB_FIRST   = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ppi_state_e;

   // ceil(log2(n)) for n >= 2; evaluated at elaboration time
   function automatic int unsigned ppi_clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage : ppi_pkg

// File: rtl/ppi_sat.sv
// ppi_sat: reduces one signed channel slice to the output sample width.
//   Macro PPI_SERIALIZER_SAT_EN defined   -> signed saturation
//   Macro PPI_SERIALIZER_SAT_EN undefined -> truncation to the LSBs (wrap)
// Ports:
//   slice_i  [gp_in_width]  : signed channel slice
//   data_c_o [gp_out_width] : reduced sample (combinational)
module ppi_sat #(
   parameter int unsigned gp_in_width  = 32,
   parameter int unsigned gp_out_width = 16
) (
   input  logic [gp_in_width-1:0]  slice_i,
   output logic [gp_out_width-1:0] data_c_o
);

   localparam int unsigned HW = gp_in_width - gp_out_width;

`ifdef PPI_SERIALIZER_SAT_EN
   if (HW > 0) begin : g_sat
      localparam logic [gp_out_width-1:0] SAT_MAX = {1'b0, {(gp_out_width-1){1'b1}}};
      localparam logic [gp_out_width-1:0] SAT_MIN = {1'b1, {(gp_out_width-1){1'b0}}};

      // output sign bit plus every discarded bit: in range only if all equal
      logic [HW:0] head_c;
      assign head_c = slice_i[gp_in_width-1 -: HW+1];

      always_comb begin
         data_c_o = slice_i[gp_out_width-1:0];
         if ((head_c != '0) && (head_c != '1)) begin
            data_c_o = head_c[HW] ? SAT_MIN : SAT_MAX;
         end
      end
   end else begin : g_pass
      assign data_c_o = slice_i;
   end
`else
   assign data_c_o = slice_i[gp_out_width-1:0];

   if (HW > 0) begin : g_drop
      // discarded upper bits are intentionally ignored in wrap mode
      logic unused_hi;
      assign unused_hi = ^slice_i[gp_in_width-1:gp_out_width];
   end
`endif

endmodule : ppi_sat

// File: rtl/ppi_serializer.sv
// ppi_serializer: serializes a packed word of gp_channels polyphase results
// into one output sample per enabled cycle (output-rate domain).
// Width reduction mode is selected by macro PPI_SERIALIZER_SAT_EN
// (defined: saturate, undefined: truncate).
// Ports:
//   i_clk, i_rst_an : clock, async active-low reset
//   i_ena           : synchronous enable; nothing advances while low
//   i_valid, i_data : new packed word strobe / packed signed slices
//   o_data, o_valid : registered serialized sample and its valid flag
//   o_ovf           : pulse when a word is replaced before fully emitted
module ppi_serializer
   import ppi_pkg::*;
#(
   parameter int unsigned gp_channels    = PPI_CHANNELS,
   parameter int unsigned gp_chan_width  = PPI_CHAN_WIDTH,
   parameter int unsigned gp_odata_width = PPI_ODATA_WIDTH,
   parameter int unsigned gp_msb_first   = PPI_MSB_FIRST
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_an,
   input  logic                                 i_ena,
   input  logic                                 i_valid,
   input  logic [gp_channels*gp_chan_width-1:0] i_data,
   output logic [gp_odata_width-1:0]            o_data,
   output logic                                 o_valid,
   output logic                                 o_ovf
);

   localparam int unsigned PW = ppi_clog2(gp_channels);
   localparam logic [PW-1:0] LAST_PHASE = PW'(gp_channels - 1);

   ppi_state_e                                   state_q, state_d;
   logic [PW-1:0]                                phase_q, phase_d;
   logic [gp_channels-1:0][gp_chan_width-1:0]    shadow_q, shadow_d;
   logic [gp_odata_width-1:0]                    data_q, data_d;
   logic                                         valid_q, valid_d;
   logic                                         ovf_q, ovf_d;

   logic [PW-1:0]                                sel_c;
   logic [gp_chan_width-1:0]                     slice_c;
   logic [gp_odata_width-1:0]                    reduced_c;

   // state register
   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      if (i_ena) begin
         case (state_q)
            ST_IDLE: if (i_valid) state_d = ST_RUN;
            ST_RUN:  if (!i_valid && (phase_q == LAST_PHASE)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // emission order and width reduction of the current slice
   assign sel_c   = (gp_msb_first != 0) ? (LAST_PHASE - phase_q) : phase_q;
   assign slice_c = shadow_q[sel_c];

   ppi_sat #(
      .gp_in_width  (gp_chan_width),
      .gp_out_width (gp_odata_width)
   ) u_sat (
      .slice_i  (slice_c),
      .data_c_o (reduced_c)
   );

   // datapath / output next values
   always_comb begin
      phase_d  = phase_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      if (i_ena) begin
         case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  shadow_d = i_data;
                  phase_d  = '0;
               end
            end
            ST_RUN: begin
               data_d  = reduced_c;
               valid_d = 1'b1;
               if (i_valid) begin
                  // recapture; only an early replacement counts as overflow
                  shadow_d = i_data;
                  phase_d  = '0;
                  ovf_d    = (phase_q != LAST_PHASE);
               end else begin
                  phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // datapath / output registers
   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         phase_q  <= '0;
         shadow_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_ovf   = ovf_q;

endmodule : ppi_serializer

// File: tb/tb_ppi_serializer.sv
// Bench for ppi_serializer: three instances share stimulus
//   u_lsb : 4 x 8 -> 8, slice 0 first
//   u_msb : 4 x 8 -> 8, slice 3 first
//   u_nar : 4 x 8 -> 4, slice 0 first (width reduction)
module tb_ppi_serializer;

   localparam logic [31:0] WORD_A = 32'h0403_0201;
   localparam logic [31:0] WORD_B = 32'h0807_0605;
   localparam logic [31:0] WORD_S = 32'h01FF_807F;
`ifdef PPI_SERIALIZER_SAT_EN
   localparam logic [3:0] RED_7F = 4'h7;
   localparam logic [3:0] RED_80 = 4'h8;
`else
   localparam logic [3:0] RED_7F = 4'hF;
   localparam logic [3:0] RED_80 = 4'h0;
`endif

   logic        clk = 1'b0;
   logic        rst_an;
   logic        ena;
   logic        valid;
   logic [31:0] data;

   logic [7:0]  d0, d1;
   logic [3:0]  d2;
   logic        v0, v1, v2, f0, f1, f2;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [3:0] q2[$];

   always #5 clk = ~clk;

   ppi_serializer #(.gp_channels(4), .gp_chan_width(8), .gp_odata_width(8), .gp_msb_first(0)) u_lsb (
      .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena), .i_valid(valid), .i_data(data),
      .o_data(d0), .o_valid(v0), .o_ovf(f0));

   ppi_serializer #(.gp_channels(4), .gp_chan_width(8), .gp_odata_width(8), .gp_msb_first(1)) u_msb (
      .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena), .i_valid(valid), .i_data(data),
      .o_data(d1), .o_valid(v1), .o_ovf(f1));

   ppi_serializer #(.gp_channels(4), .gp_chan_width(8), .gp_odata_width(4), .gp_msb_first(0)) u_nar (
      .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena), .i_valid(valid), .i_data(data),
      .o_data(d2), .o_valid(v2), .o_ovf(f2));

   // reference width reduction of an 8-bit signed slice to 4 bits
   function automatic logic [3:0] exp_red(input logic [7:0] s);
`ifdef PPI_SERIALIZER_SAT_EN
      if ($signed(s) > 7)  return 4'h7;
      if ($signed(s) < -8) return 4'h8;
`endif
      return s[3:0];
   endfunction

   // expected samples for the first n phases of word w, per instance
   task automatic push_word(input logic [31:0] w, input int n);
      logic [7:0] s;
      for (int k = 0; k < n; k++) begin
         s = w[8*k +: 8];
         q0.push_back(s);
         q2.push_back(exp_red(s));
         s = w[8*(3-k) +: 8];
         q1.push_back(s);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // scoreboard: every valid output sample is popped and compared
   always @(negedge clk) begin
      logic [7:0] e8;
      logic [3:0] e4;
      if (v0 === 1'b1) begin
         n_cmp++;
         if (q0.size() == 0) begin
            n_err++;
            $display("FAIL sb_lsb: got unexpected sample %h, expected none", d0);
         end else begin
            e8 = q0.pop_front();
            if (d0 !== e8) begin
               n_err++;
               $display("FAIL sb_lsb: got %h, expected %h at %0t", d0, e8, $time);
            end
         end
      end
      if (v1 === 1'b1) begin
         n_cmp++;
         if (q1.size() == 0) begin
            n_err++;
            $display("FAIL sb_msb: got unexpected sample %h, expected none", d1);
         end else begin
            e8 = q1.pop_front();
            if (d1 !== e8) begin
               n_err++;
               $display("FAIL sb_msb: got %h, expected %h at %0t", d1, e8, $time);
            end
         end
      end
      if (v2 === 1'b1) begin
         n_cmp++;
         if (q2.size() == 0) begin
            n_err++;
            $display("FAIL sb_nar: got unexpected sample %h, expected none", d2);
         end else begin
            e4 = q2.pop_front();
            if (d2 !== e4) begin
               n_err++;
               $display("FAIL sb_nar: got %h, expected %h at %0t", d2, e4, $time);
            end
         end
      end
   end

   task automatic test_reset();
      rst_an = 1'b1;
      ena    = 1'b0;
      valid  = 1'b0;
      data   = '0;
      #2 rst_an = 1'b0;
      #1;
      n_cmp++;
      if ({d0, d1, d2, v0, v1, v2, f0, f1, f2} !== 29'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h, expected 0", {d0, d1, d2, v0, v1, v2, f0, f1, f2});
      end
      @(negedge clk);
      @(negedge clk);
      rst_an = 1'b1;
      ena    = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      push_word(WORD_A, 4);
      valid = 1'b1;
      data  = WORD_A;
      tick();
      valid = 1'b0;
      n_cmp++;
      if ({v0, v1, v2} !== 3'b000) begin
         n_err++;
         $display("FAIL single_latency: o_valid %b on capture cycle, expected 000", {v0, v1, v2});
      end
      for (int c = 1; c <= 5; c++) begin
         tick();
         n_cmp++;
         if ({v0, v1, v2, f0, f1, f2} !== ((c <= 4) ? 6'b111000 : 6'b000000)) begin
            n_err++;
            $display("FAIL single_flags c%0d: valid/ovf %b", c, {v0, v1, v2, f0, f1, f2});
         end
      end
   endtask

   task automatic test_back_to_back();
      push_word(WORD_A, 4);
      push_word(WORD_B, 4);
      for (int c = 0; c <= 9; c++) begin
         valid = (c == 0) || (c == 4);
         data  = (c < 4) ? WORD_A : WORD_B;
         tick();
         n_cmp++;
         if ({v0, v1, v2, f0, f1, f2} !== (((c >= 1) && (c <= 8)) ? 6'b111000 : 6'b000000)) begin
            n_err++;
            $display("FAIL b2b_flags c%0d: valid/ovf %b", c, {v0, v1, v2, f0, f1, f2});
         end
      end
      valid = 1'b0;
   endtask

   task automatic test_overrun();
      logic [5:0] exp;
      push_word(WORD_A, 2);
      push_word(WORD_B, 4);
      for (int c = 0; c <= 7; c++) begin
         valid = (c == 0) || (c == 2);
         data  = (c < 2) ? WORD_A : WORD_B;
         tick();
         exp = 6'b000000;
         if ((c >= 1) && (c <= 6)) exp[5:3] = 3'b111;
         if (c == 2)               exp[2:0] = 3'b111;
         n_cmp++;
         if ({v0, v1, v2, f0, f1, f2} !== exp) begin
            n_err++;
            $display("FAIL ovr_flags c%0d: valid/ovf %b, expected %b", c, {v0, v1, v2, f0, f1, f2}, exp);
         end
      end
      valid = 1'b0;
   endtask

   task automatic test_width();
      push_word(WORD_S, 4);
      valid = 1'b1;
      data  = WORD_S;
      tick();
      valid = 1'b0;
      tick();
      n_cmp++;
      if (d2 !== RED_7F) begin
         n_err++;
         $display("FAIL width_7f: got %h, expected %h", d2, RED_7F);
      end
      tick();
      n_cmp++;
      if (d2 !== RED_80) begin
         n_err++;
         $display("FAIL width_80: got %h, expected %h", d2, RED_80);
      end
      repeat (3) tick();
   endtask

   task automatic test_ena_reset();
      push_word(WORD_A, 3);
      valid = 1'b1;
      data  = WORD_A;
      tick();
      valid = 1'b0;
      tick();
      tick();
      ena = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if ({v0, v1, v2, f0, f1, f2} !== 6'b000000 || d0 !== 8'h02 || d1 !== 8'h03 || d2 !== exp_red(8'h02)) begin
            n_err++;
            $display("FAIL ena_hold c%0d: flags %b data %h/%h/%h, expected 000000 02/03/%h",
                     c, {v0, v1, v2, f0, f1, f2}, d0, d1, d2, exp_red(8'h02));
         end
      end
      ena = 1'b1;
      tick();
      #2 rst_an = 1'b0;
      #1;
      n_cmp++;
      if ({d0, d1, d2, v0, v1, v2, f0, f1, f2} !== 29'd0) begin
         n_err++;
         $display("FAIL mid_reset: got %h, expected 0", {d0, d1, d2, v0, v1, v2, f0, f1, f2});
      end
      @(negedge clk);
      @(negedge clk);
      rst_an = 1'b1;
      // strobe while disabled must not capture
      ena   = 1'b0;
      valid = 1'b1;
      data  = WORD_B;
      tick();
      valid = 1'b0;
      ena   = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_cmp++;
         if ({v0, v1, v2} !== 3'b000 || {d0, d1, d2} !== 20'd0) begin
            n_err++;
            $display("FAIL post_reset c%0d: valid %b data %h, expected 000 0", c, {v0, v1, v2}, {d0, d1, d2});
         end
      end
      push_word(WORD_B, 4);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_drain();
      n_cmp++;
      if (q0.size() + q1.size() + q2.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d/%0d/%0d samples outstanding, expected 0", q0.size(), q1.size(), q2.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_width();
      test_ena_reset();
      test_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation limit reached");
      $fatal(1, "timeout");
   end

endmodule : tb_ppi_serializer

// File: doc/ppi_serializer.md
PPI_SERIALIZER -- requirements
Module: ppi_serializer

Interface
REQ-001 gp_channels, 32, number of polyphase channels packed in i_data (equals upstream interpolation factor); SHALL be >= 2.
REQ-002 gp_chan_width, 32, bit-width of one packed signed channel slice.
REQ-003 gp_odata_width, 16, bit-width of the serialized output sample; SHALL satisfy gp_odata_width <= gp_chan_width.
REQ-004 gp_msb_first, 0, emission order: 0 -> slice 0 (LSBs of i_data) first; 1 -> slice gp_channels-1 first.
REQ-005 i_clk  input  1  rising-edge clock, output-rate domain.
REQ-006 i_rst_an  input  1  reset, asynchronous, active-low.
REQ-007 i_ena  input  1  synchronous active-high enable; all state advances only when high.
REQ-008 i_valid  input  1  one-cycle strobe marking a new packed word on i_data (input-rate tick).
REQ-009 i_data  input  gp_channels*gp_chan_width  packed signed channel results, slice k at [(k+1)*gp_chan_width-1 -: gp_chan_width].
REQ-010 o_data  output  gp_odata_width  serialized signed output sample, registered.
REQ-011 o_valid  output  1  high for each cycle o_data carries a new sample.
REQ-012 o_ovf  output  1  one-cycle pulse: packed word replaced before all its phases were emitted.

Function
REQ-013 States SHALL be IDLE and RUN; a phase counter SHALL run 0..gp_channels-1, width clog2(gp_channels).
REQ-014 IDLE, i_ena=1, i_valid=1: SHALL capture i_data into a shadow register, set phase=0, enter RUN.
REQ-015 Latency: first output SHALL appear on o_data/o_valid the cycle after capture; one sample per enabled cycle thereafter.
REQ-016 RUN, i_ena=1, i_valid=0: SHALL emit slice order(phase), increment phase; after phase gp_channels-1 SHALL return to IDLE.
REQ-017 RUN, i_valid=1 on the cycle the final phase is emitted: SHALL recapture, restart at phase 0, stay in RUN, no gap in o_valid, o_ovf=0.
REQ-018 RUN, i_valid=1 at any earlier phase: SHALL recapture, restart at phase 0, pulse o_ovf for one cycle; remaining old phases are dropped.
REQ-019 i_ena=0: all state, counter, shadow and o_data SHALL hold; o_valid and o_ovf SHALL be 0.
REQ-020 IDLE without i_valid: o_valid=0, o_data SHALL hold its last value.
REQ-021 order(phase) SHALL be phase when gp_msb_first=0, gp_channels-1-phase when 1.
REQ-022 Width reduction of the selected slice to gp_odata_width SHALL follow REQ-026/REQ-027.

Reset
REQ-023 On i_rst_an low: state=IDLE, phase=0, shadow=0, o_data=0, o_valid=0, o_ovf=0, immediately and asynchronously.
REQ-024 Reset asserted mid-RUN SHALL discard the pending word; after release, no output until the next i_valid.

Configuration
REQ-025 Macro PPI_SERIALIZER_SAT_EN selects width-reduction mode.
REQ-026 Defined: slice SHALL be saturated to the signed gp_odata_width range (max 2^(gp_odata_width-1)-1, min -2^(gp_odata_width-1)).
REQ-027 Undefined: slice SHALL be truncated to its gp_odata_width LSBs (two's-complement wrap); identical when widths are equal.

Structure
REQ-028 Package ppi_pkg SHALL hold the state enum, the clog2 helper function and the default parameter constants.
REQ-029 One sub-module, ppi_sat, SHALL perform slice-to-output width reduction (saturate or truncate per macro); counter/FSM stay in ppi_serializer.

Verification (gp_channels=4, gp_chan_width=8, gp_odata_width=8 unless stated)
REQ-030 i_data=0x04030201, i_valid 1 cycle, i_ena=1 -> o_data 0x01,0x02,0x03,0x04 on next 4 cycles, o_valid=1 each, then 0.
REQ-031 Same stimulus, gp_msb_first=1 -> o_data 0x04,0x03,0x02,0x01.
REQ-032 i_valid every 4 cycles, words 0x04030201 then 0x08070605 -> continuous o_valid, 0x01..0x08 in order, o_ovf=0.
REQ-033 i_valid with 0x04030201, second i_valid with 0x08070605 two cycles later -> outputs 0x01,0x02,0x05,0x06,0x07,0x08, o_ovf pulse aligned with the second capture.
REQ-034 gp_odata_width=4, slice 0x7F: with PPI_SERIALIZER_SAT_EN -> 0x7; without -> 0xF; slice 0x80 -> 0x8 (SAT) / 0x0 (trunc).
REQ-035 i_ena low 3 cycles after second output, then reset low mid-RUN -> outputs frozen while disabled, o_valid=0; on reset all outputs 0, none resume until new i_valid.
